// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: routes one valid/ready stream to one of two outputs.
// Ports: clk, rst_n, in_* producer side, out0_*/out1_* consumer sides,
// plus cnt0/cnt1 handshake counters when DEMUX_COUNT_EN is defined.
// Each output owns a DEPTH-entry FIFO so a stalled consumer never blocks
// beats addressed to the other one.
module stream_demux_1to2 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       rdy_out;
  logic [WIDTH-1:0] head [2];

  assign rdy_out = {out1_ready, out0_ready};

  // Depends only on in_sel and registered occupancy, never on outN_ready.
  assign in_ready = ~full[in_sel];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    wptr_d;
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    rptr_d;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_d;

    assign full[g]  = (occ_q == CW'(DEPTH));
    assign empty[g] = (occ_q == '0);
    assign push[g]  = in_valid & in_ready
                    & (in_sel == (g != 0));
    assign pop[g]   = ~empty[g] & rdy_out[g];
    assign head[g]  = empty[g] ? '0 : mem_q[rptr_q];

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (push[g]) wptr_d = wptr_q + AW'(1);
      if (pop[g])  rptr_d = rptr_q + AW'(1);
      unique case ({push[g], pop[g]})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        occ_q  <= occ_d;
      end
    end

    // Storage is not reset; the zeroed occupancy hides stale entries.
    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wptr_q] <= in_data;
    end
  end

  assign out0_valid = ~empty[0];
  assign out1_valid = ~empty[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt0_d;
  logic [15:0] cnt1_q;
  logic [15:0] cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop[0]) cnt0_d = cnt0_q + 16'd1;
    if (pop[1]) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: scoreboard bench for stream_demux_1to2.
// Directed scenarios plus random traffic; per-output expected queues.
module tb_stream_demux_1to2;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int total;
  int bad;
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  stream_demux_1to2 #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out0_data(out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data(out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Handshakes are decided at the negedge before the active edge;
  // pops are checked against older entries before the new push.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        chk("out0_pending", 32'(exp0.size() > 0), 32'd1);
        if (exp0.size() > 0)
          chk("out0_data", 32'(out0_data), 32'(exp0.pop_front()));
      end
      if (out1_valid && out1_ready) begin
        chk("out1_pending", 32'(exp1.size() > 0), 32'd1);
        if (exp1.size() > 0)
          chk("out1_data", 32'(out1_data), 32'(exp1.pop_front()));
      end
      if (in_valid && in_ready) begin
        if (in_sel) exp1.push_back(in_data);
        else        exp0.push_back(in_data);
      end
    end
  end

  task automatic drive(input logic v, input logic s,
                       input logic [15:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_v0"}, 32'(out0_valid), 32'd0);
    chk({tag, "_v1"}, 32'(out1_valid), 32'd0);
    chk({tag, "_d0"}, 32'(out0_data), 32'd0);
    chk({tag, "_d1"}, 32'(out1_data), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    int n;
    drive(1'b0, 1'b0, 16'h0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    n = 0;
    while ((exp0.size() > 0 || exp1.size() > 0) && n < 20) begin
      step();
      n++;
    end
    step();
    chk("drain_q0", 32'(exp0.size()), 32'd0);
    chk("drain_q1", 32'(exp1.size()), 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b0, 1'b0, 16'h0);
    #3;
    chk_reset_outs("por");
    step();
    step();
    rst_n = 1'b1;

    // Alternating routing
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h1111);
    sample();
    chk("alt_rdy0", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 1'b1, 16'h2222);
    sample();
    chk("alt_v0", 32'(out0_valid), 32'd1);
    chk("alt_d0", 32'(out0_data), 32'h1111);
    step();
    drive(1'b0, 1'b0, 16'h0);
    sample();
    chk("alt_v1", 32'(out1_valid), 32'd1);
    chk("alt_d1", 32'(out1_data), 32'h2222);
    chk("alt_e0", 32'(out0_valid), 32'd0);
    step();
    step();

    // Fill and back-pressure
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 16'hA000);
    step();
    drive(1'b1, 1'b0, 16'hA001);
    step();
    drive(1'b1, 1'b0, 16'hA002);
    sample();
    chk("bp_full", 32'(in_ready), 32'd0);
    step();
    drive(1'b1, 1'b1, 16'hB000);
    sample();
    chk("bp_other", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0);
    out1_ready = 1'b1;
    sample();
    chk("bp_v1", 32'(out1_valid), 32'd1);
    chk("bp_d1", 32'(out1_data), 32'hB000);
    chk("bp_d0", 32'(out0_data), 32'hA000);
    step();

    // Full FIFO with consumer ready: still stalls this cycle
    drive(1'b1, 1'b0, 16'hA002);
    out0_ready = 1'b1;
    sample();
    chk("fp_now", 32'(in_ready), 32'd0);
    step();
    sample();
    chk("fp_next", 32'(in_ready), 32'd1);
    step();
    drain();

    // Streaming push+pop on FIFO 0
    out0_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 16'(i));
      sample();
      chk("str_rdy", 32'(in_ready), 32'd1);
      chk("str_occ", 32'(exp0.size() <= 1), 32'd1);
      step();
    end
    drain();

    // Random mix
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom));
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    drain();

    // Reset mid-operation with both FIFOs holding data
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i), 16'h7700 + 16'(i));
      step();
    end
    drive(1'b0, 1'b0, 16'h0);
    sample();
    chk("pre_rst_v0", 32'(out0_valid), 32'd1);
    chk("pre_rst_v1", 32'(out1_valid), 32'd1);
    chk("pre_rst_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    exp0.delete();
    exp1.delete();
    step();
    rst_n = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 16'h5A5A);
    sample();
    chk("post_rdy", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0);
    sample();
    chk("post_d1", 32'(out1_data), 32'h5A5A);
    chk("post_v0", 32'(out0_valid), 32'd0);
    step();
    drain();

`ifdef DEMUX_COUNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("cnt_rst1", 32'(cnt1), 32'd0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 1'b1, 16'(i));
      step();
    end
    drain();
    chk("cnt1_wrap", 32'(cnt1), 32'd1);
    chk("cnt0_idle", 32'(cnt0), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
